// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and patch-geometry helpers for col2im_2d.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

    function automatic int n_pos(input int img, input int k, input int s, input int p);
        return (img - k + 2 * p) / s + 1;
    endfunction

    function automatic int h_pos(input int iw, input int k, input int s, input int p);
        return n_pos(iw, k, s, p);
    endfunction

    function automatic int v_pos(input int ih, input int k, input int s, input int p);
        return n_pos(ih, k, s, p);
    endfunction

    function automatic int n_in(input int iw, input int ih, input int k, input int s, input int p);
        return k * k * h_pos(iw, k, s, p) * v_pos(ih, k, s, p);
    endfunction

    function automatic int cw(input int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/col2im_addr_gen.sv
// col2im_addr_gen: maps patch/kernel counters to an image coordinate plus an in-image flag.
module col2im_addr_gen
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int PW = cw(h_pos(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING) >
                          v_pos(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING) ?
                          h_pos(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING) :
                          v_pos(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING)),
    parameter int KW = cw(KERNEL_SIZE),
    parameter int YW = cw(IMAGE_HEIGHT),
    parameter int XW = cw(IMAGE_WIDTH)
) (
    input  logic [PW-1:0] pr,
    input  logic [PW-1:0] pc,
    input  logic [KW-1:0] kr,
    input  logic [KW-1:0] kc,
    output logic [YW-1:0] y,
    output logic [XW-1:0] x,
    output logic          in_bounds
);

    int yi, xi;

    always_comb begin
        yi        = int'(pr) * STRIDE + int'(kr) - PADDING;
        xi        = int'(pc) * STRIDE + int'(kc) - PADDING;
        in_bounds = yi >= 0 && yi < IMAGE_HEIGHT && xi >= 0 && xi < IMAGE_WIDTH;
        y         = YW'(yi);
        x         = XW'(xi);
    end

endmodule

// File: rtl/col2im_2d.sv
// col2im_2d: folds a column-matrix stream back into an image by overlap-add, then streams pixels out.
// Define COL2IM_SATURATE_EN to clamp accumulators at full scale instead of wrapping.
module col2im_2d
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 4,
    parameter int IMAGE_HEIGHT = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 8,
    parameter int ACC_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int H_POS = h_pos(IMAGE_WIDTH, KERNEL_SIZE, STRIDE, PADDING);
    localparam int V_POS = v_pos(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE, PADDING);
    localparam int NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int PW    = cw(H_POS > V_POS ? H_POS : V_POS);
    localparam int KW    = cw(KERNEL_SIZE);
    localparam int YW    = cw(IMAGE_HEIGHT);
    localparam int XW    = cw(IMAGE_WIDTH);
    localparam int IW    = cw(NPIX);

    state_t               state_q, state_d;
    logic [PW-1:0]        pr_q, pr_d, pc_q, pc_d;
    logic [KW-1:0]        kr_q, kr_d, kc_q, kc_d;
    logic [IW-1:0]        pix_q, pix_d;
    logic                 done_q, done_d;
    logic [ACC_WIDTH-1:0] acc_q [NPIX];
    logic [ACC_WIDTH-1:0] acc_d [NPIX];
    logic [YW-1:0]        y;
    logic [XW-1:0]        x;
    logic                 in_bounds;
    logic [IW-1:0]        idx;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] wr;
    logic                 in_hs, out_hs, kc_end, kr_end, pc_end, last_in;

    col2im_addr_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .KERNEL_SIZE (KERNEL_SIZE),
        .STRIDE      (STRIDE),
        .PADDING     (PADDING),
        .PW          (PW),
        .KW          (KW),
        .YW          (YW),
        .XW          (XW)
    ) u_addr (
        .pr       (pr_q),
        .pc       (pc_q),
        .kr       (kr_q),
        .kc       (kc_q),
        .y        (y),
        .x        (x),
        .in_bounds(in_bounds)
    );

    always_comb begin
        state_d   = state_q;
        pr_d      = pr_q;
        pc_d      = pc_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        pix_d     = pix_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        busy      = state_q != IDLE;
        done      = done_q;
        in_ready  = state_q == ACCUM;
        out_valid = state_q == DRAIN;
        out_data  = out_valid ? acc_q[pix_q] : '0;
        out_last  = out_valid && pix_q == IW'(NPIX - 1);
        in_hs     = in_valid && in_ready;
        out_hs    = out_valid && out_ready;
        kc_end    = kc_q == KW'(KERNEL_SIZE - 1);
        kr_end    = kc_end && kr_q == KW'(KERNEL_SIZE - 1);
        pc_end    = kr_end && pc_q == PW'(H_POS - 1);
        last_in   = pc_end && pr_q == PW'(V_POS - 1);
        idx       = IW'(int'(y) * IMAGE_WIDTH + int'(x));
        sum       = {1'b0, acc_q[idx]} + (ACC_WIDTH + 1)'(in_data);
`ifdef COL2IM_SATURATE_EN
        wr        = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
        wr        = sum[ACC_WIDTH-1:0];
`endif
        case (state_q)
            IDLE: if (start) state_d = CLEAR;
            CLEAR: begin
                acc_d   = '{default: '0};
                pr_d    = '0;
                pc_d    = '0;
                kr_d    = '0;
                kc_d    = '0;
                pix_d   = '0;
                state_d = ACCUM;
            end
            ACCUM: if (in_hs) begin
                // Single-cycle read-modify-write keeps back-to-back hits on one pixel exact.
                if (in_bounds) acc_d[idx] = wr;
                kc_d = kc_end ? '0 : kc_q + KW'(1);
                kr_d = kr_end ? '0 : kc_end ? kr_q + KW'(1) : kr_q;
                pc_d = pc_end ? '0 : kr_end ? pc_q + PW'(1) : pc_q;
                pr_d = last_in ? '0 : pc_end ? pr_q + PW'(1) : pr_q;
                state_d = last_in ? DRAIN : ACCUM;
            end
            DRAIN: if (out_hs) begin
                pix_d   = out_last ? '0 : pix_q + IW'(1);
                state_d = out_last ? IDLE : DRAIN;
                done_d  = out_last;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pr_q    <= '0;
            pc_q    <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) acc_q <= acc_d;

endmodule
